// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, step mode
// and the sequencer states.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply or restoring shift-subtract
// divide on a 2*WIDTH+1 accumulator {upper/remainder, lower/quotient}.
module muldiv_step import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  opnd_i,
    input  logic              mode_i,
    output logic [2*WIDTH:0]  acc_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        acc_o   = acc_i;
        mul_sum = acc_i[2*WIDTH:WIDTH];
        rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        quo_sh  = {acc_i[WIDTH-2:0], 1'b0};
        diff    = {1'b0, rem_sh} - {2'b00, opnd_i};

        if (mode_i == MODE_DIV) begin
            // A borrow means the trial subtraction failed: restore and shift in 0.
            if (diff[WIDTH+1]) begin
                acc_o = {rem_sh, quo_sh};
            end else begin
                acc_o = {diff[WIDTH:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (acc_i[0]) begin
                mul_sum = acc_i[2*WIDTH:WIDTH] + {1'b0, opnd_i};
            end
            acc_o = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and a
// start/busy/done handshake; one bit per clock on operand magnitudes.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH:0]   acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_a_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH:0]   acc_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    // Magnitudes on a WIDTH-bit unsigned datapath, so |MIN| wraps to MIN's bit pattern.
    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        a_abs = a_neg ? -a : a;
        b_abs = b_neg ? -b : b;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .mode_i (is_div_q),
        .acc_o  (acc_d)
    );

    always_comb begin
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        prod_fix = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        if (is_div_q) begin
            lo_fix = neg_res_q ? -quo : quo;
            hi_fix = neg_a_q ? -rem : rem;
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_a_q   <= a_neg;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (op[1] && (b == '0)) begin
                            hi_q    <= a;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            acc_q   <= op[1] ? {{(WIDTH+1){1'b0}}, a_abs}
                                             : {{(WIDTH+1){1'b0}}, b_abs};
                            opnd_q  <= op[1] ? b_abs : a_abs;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // Sign correction feeds HI/LO directly so they are valid with done.
                    hi_q    <= hi_fix;
                    lo_q    <= lo_fix;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;
    logic        dbz8;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (dbz)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .op          (op8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .hi          (hi8),
        .lo          (lo8),
        .div_by_zero (dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a rising edge (or before one); start is sampled at the
    // next edge (cycle 0), then the operand inputs are scrambled.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = ~y;
    endtask

    // Returns the cycle index of done (0 on timeout) and whether busy held every cycle.
    task automatic wait_done(input int max_cyc, output int cyc, output logic busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, dbz} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, dbz}); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
        checks++; if ({busy8, done8, dbz8, hi8, lo8} !== 19'h0) begin errors++; $display("FAIL reset_w8 got %h want 0", {busy8, done8, dbz8, hi8, lo8}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_multu_max();
        int   cyc;
        logic bok;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(60, cyc, bok);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", cyc); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL multu_busy got %b want 1", bok); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL multu_dbz got %b want 0", dbz); end
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL multu_after_done got %b want 00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic bok;
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(60, cyc, bok);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", lo); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(60, cyc, bok);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", cyc); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    endtask

    task automatic test_div_edges();
        int   cyc;
        logic bok;
        @(posedge clk); #1;
        launch(OP_DIVU, 32'd100, 32'd0);
        wait_done(60, cyc, bok);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", cyc); end
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", dbz); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin errors++; $display("FAIL dbz_hi got %h want 00000064", hi); end
        @(posedge clk); #1;
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(60, cyc, bok);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL min_div_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL min_div_hi got %h want 00000000", hi); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL min_div_dbz got %b want 0", dbz); end
    endtask

    task automatic test_ignored_start();
        int          cyc;
        int          extra;
        logic [31:0] hi_c;
        logic [31:0] lo_c;
        cyc = 0; extra = 0; hi_c = '0; lo_c = '0;
        @(posedge clk); #1;
        launch(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c <= 80; c++) begin
            if (c == 10) begin
                start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1;
            end
            if (c == 11) begin
                start = 1'b0;
                checks++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL ign_hold got %h want 0000000080000000", {hi, lo}); end
            end
            if (done) begin
                if (cyc == 0) begin
                    cyc = c; hi_c = hi; lo_c = lo;
                end else begin
                    extra++;
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (cyc !== 34) begin errors++; $display("FAIL ign_latency got %0d want 34", cyc); end
        checks++; if (lo_c !== 32'd14) begin errors++; $display("FAIL ign_lo got %h want 0000000e", lo_c); end
        checks++; if (hi_c !== 32'd2) begin errors++; $display("FAIL ign_hi got %h want 00000002", hi_c); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ign_extra_done got %0d want 0", extra); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL ign_hold_after got %h want 000000020000000e", {hi, lo}); end
    endtask

    task automatic test_reset_inflight();
        int   cyc;
        int   n_done;
        logic bok;
        n_done = 0;
        launch(OP_MULTU, 32'h1234_5678, 32'h0000_0009);
        repeat (14) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst15_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, dbz} !== 3'b000) begin errors++; $display("FAIL rst15_flags got %b want 000", {busy, done, dbz}); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst15_hilo got %h want 0", {hi, lo}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rst15_no_done got %0d want 0", n_done); end
        launch(OP_MULTU, 32'd6, 32'd7);
        wait_done(60, cyc, bok);
        checks++; if (cyc !== 34) begin errors++; $display("FAIL rst15_fresh_latency got %0d want 34", cyc); end
        checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL rst15_fresh_prod got %h want 000000000000002a", {hi, lo}); end
    endtask

    task automatic test_width8();
        int cyc;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            op8    = (k == 0) ? OP_DIV : OP_MULTU;
            a8     = (k == 0) ? 8'h81 : 8'hFF;
            b8     = (k == 0) ? 8'h0A : 8'hFF;
            start8 = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
            cyc = 0;
            for (int c = 1; c <= 30; c++) begin
                if (done8) begin
                    cyc = c;
                    break;
                end
                @(posedge clk); #1;
            end
            checks++; if (cyc !== 10) begin errors++; $display("FAIL w8_latency_%0d got %0d want 10", k, cyc); end
            if (k == 0) begin
                checks++; if ({hi8, lo8} !== 16'hF9F4) begin errors++; $display("FAIL w8_div got %h want f9f4", {hi8, lo8}); end
            end else begin
                checks++; if ({hi8, lo8} !== 16'hFE01) begin errors++; $display("FAIL w8_multu got %h want fe01", {hi8, lo8}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_div_edges();
        test_ignored_start();
        test_reset_inflight();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
